// File: rtl/uart_rx_os.sv
// ---------------------------------------------------------------------------
// uart_rx_os
//
// Single-clock oversampling UART receiver. The serial line is brought into the
// clk domain by a 2-flop synchronizer, every bit is timed by an internal
// DIV-cycle divider, and each bit is decided by a 2-of-3 majority vote of the
// samples taken at cnt = DIV/2-1, DIV/2 and DIV/2+1. Received bytes are
// delivered with a valid/ack handshake plus framing and overrun flags.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   : 11-bit frame (start, 8 data LSB first, even parity, stop);
//               parity_err pulses together with ready on a parity mismatch.
//   undefined : 10-bit frame; parity_err is tied 0.
//
// Parameters
//   DIV        clk cycles per bit, legal 4..255
// Ports
//   clk        sample clock, all logic on the rising edge
//   reset_n    synchronous active-low reset
//   in         serial line, idle high, asynchronous to clk
//   ack        consumer has taken out; clears valid
//   out        last good byte (LSB received first)
//   ready      one-cycle pulse when out is updated
//   valid      level, out holds an unconsumed byte
//   busy       frame in progress (START/DATA/PARITY/STOP)
//   frame_err  one-cycle pulse on a bad stop bit
//   overrun    one-cycle pulse when a byte lands while valid=1 and ack=0
//   parity_err one-cycle pulse on an even-parity mismatch (parity build only)
// ---------------------------------------------------------------------------
module uart_rx_os #(
    parameter int DIV = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in,
    input  logic       ack,
    output logic [7:0] out,
    output logic       ready,
    output logic       valid,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);

    localparam int         HALF   = DIV / 2;
    localparam logic [7:0] C_S0   = 8'(HALF - 1);
    localparam logic [7:0] C_S1   = 8'(HALF);
    localparam logic [7:0] C_DEC  = 8'(HALF + 1);
    localparam logic [7:0] C_LAST = 8'(DIV - 1);

    typedef enum logic [2:0] {
        ST_ARM,
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP
    } state_t;

    state_t     r_state;
    logic       r_sync1;
    logic       r_sync2;
    logic [7:0] r_cnt;
    logic [3:0] r_idx;
    logic       r_s0;
    logic       r_s1;
    logic [7:0] r_shift;
    logic [7:0] r_out;
    logic       r_ready;
    logic       r_valid;
    logic       r_busy;
    logic       r_frame_err;
    logic       r_overrun;
`ifdef UART_RX_PARITY_EN
    logic       r_par;
    logic       r_parity_err;
`endif

    logic w_rx_s;
    logic w_vote;
    logic w_decide;
    logic w_wrap;

    assign w_rx_s   = r_sync2;
    // Third sample is the live synchronized line at the decision count.
    assign w_vote   = (r_s0 & r_s1) | (r_s0 & w_rx_s) | (r_s1 & w_rx_s);
    assign w_decide = (r_cnt == C_DEC);
    assign w_wrap   = (r_cnt == C_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_state     <= ST_ARM;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_s0        <= 1'b1;
            r_s1        <= 1'b1;
            r_shift     <= '0;
            r_out       <= '0;
            r_ready     <= 1'b0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par        <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_sync1     <= in;
            r_sync2     <= r_sync1;
            r_ready     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            // A good stop later in this block overrides the ack clear.
            if (ack) begin
                r_valid <= 1'b0;
            end

            // Outside a frame these captures are stale but harmless: a new
            // frame restarts cnt at 0 and refills both before its decision.
            if (r_cnt == C_S0) begin
                r_s0 <= w_rx_s;
            end
            if (r_cnt == C_S1) begin
                r_s1 <= w_rx_s;
            end

            case (r_state)
                ST_ARM: begin
                    if (w_rx_s) begin
                        r_state <= ST_IDLE;
                    end
                end

                ST_IDLE: begin
                    if (!w_rx_s) begin
                        r_state <= ST_START;
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                    end
                end

                default: begin
                    if (w_wrap) begin
                        r_cnt <= '0;
                        r_idx <= r_idx + 4'd1;
                        case (r_state)
                            ST_START: r_state <= ST_DATA;
                            ST_DATA: begin
                                if (r_idx == 4'd8) begin
`ifdef UART_RX_PARITY_EN
                                    r_state <= ST_PAR;
`else
                                    r_state <= ST_STOP;
`endif
                                end
                            end
                            ST_PAR:   r_state <= ST_STOP;
                            default:  ;
                        endcase
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end

                    // Placed after the wrap handling so that, at DIV=4 where
                    // decision and wrap coincide, the decision's exit wins.
                    if (w_decide) begin
                        case (r_state)
                            ST_START: begin
                                if (w_vote) begin
                                    r_state <= ST_IDLE;
                                    r_busy  <= 1'b0;
                                end
                            end
                            ST_DATA: begin
                                r_shift <= {w_vote, r_shift[7:1]};
                            end
                            ST_PAR: begin
`ifdef UART_RX_PARITY_EN
                                r_par <= w_vote;
`endif
                            end
                            ST_STOP: begin
                                r_busy <= 1'b0;
                                if (w_vote) begin
                                    // Leave at mid-stop so a back-to-back
                                    // start edge is never missed.
                                    r_state   <= ST_IDLE;
                                    r_out     <= r_shift;
                                    r_ready   <= 1'b1;
                                    r_valid   <= 1'b1;
                                    r_overrun <= r_valid & ~ack;
`ifdef UART_RX_PARITY_EN
                                    r_parity_err <= (^r_shift) ^ r_par;
`endif
                                end else begin
                                    r_state     <= ST_ARM;
                                    r_frame_err <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    assign out       = r_out;
    assign ready     = r_ready;
    assign valid     = r_valid;
    assign busy      = r_busy;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
`ifdef UART_RX_PARITY_EN
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_os.sv
`timescale 1ns/1ps
module tb_uart_rx_os;
    localparam int DIV = 8;
`ifdef UART_RX_PARITY_EN
    localparam int NB = 10;   // index of the stop bit
`else
    localparam int NB = 9;
`endif
    // First clk edge sampling the start edge -> edge registering ready.
    localparam int LAT = 2 + NB * DIV + DIV / 2 + 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       in_line = 1'b1;
    logic       ack = 1'b0;
    logic [7:0] out;
    logic       ready, valid, busy, frame_err, overrun, parity_err;

    uart_rx_os #(.DIV(DIV)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in         (in_line),
        .ack        (ack),
        .out        (out),
        .ready      (ready),
        .valid      (valid),
        .busy       (busy),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         ferr;
        logic [7:0] data;
        bit         ovr;
        bit         perr;
        int         when;
    } exp_t;

    exp_t sb[$];
    bit   ack_at[int];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_rx  = 0;

    // Reference model state: is a byte waiting unconsumed, and last good byte.
    bit         m_valid = 1'b0;
    logic [7:0] m_last  = 8'h00;

    task automatic check(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Drive one frame on the line, starting at a falling clk edge.
    // gbit: bit index receiving a one-cycle mid-bit glitch (-1 none).
    // rbit: bit index during which reset_n is pulsed low (-1 none).
    task automatic drive_frame(input logic [7:0] d, input bit stop, input bit par,
                               input int gbit, input int rbit);
        logic [10:0] bits;
        int nb;
        bits      = '0;
        bits[8:1] = d;
`ifdef UART_RX_PARITY_EN
        bits[9]  = par;
        bits[10] = stop;
        nb = 11;
`else
        bits[9]  = stop;
        bits[10] = par;
        nb = 10;
`endif
        for (int b = 0; b < nb; b++) begin
            for (int c = 0; c < DIV; c++) begin
                if (b == rbit && c == 0) reset_n = 1'b0;
                if (b == rbit && c == 2) reset_n = 1'b1;
                in_line = bits[b] ^ (b == gbit && c == DIV / 2);
                @(negedge clk);
            end
        end
    endtask

    // mode 0: ack two cycles after ready; 1: never ack; 2: ack on the
    // decision edge itself.
    task automatic send_frame(input logic [7:0] d, input bit stop, input bit par,
                              input int gbit, input int mode);
        exp_t e;
        e.when = cyc + 1 + LAT;
        if (stop) begin
            e.ferr = 1'b0;
            e.data = d;
            e.ovr  = m_valid && (mode != 2);
`ifdef UART_RX_PARITY_EN
            e.perr = (par != ^d);
`else
            e.perr = 1'b0;
`endif
            m_last  = d;
            m_valid = (mode != 0);
            if (mode == 2) ack_at[e.when] = 1'b1;
            if (mode == 0) ack_at[e.when + 2] = 1'b1;
        end else begin
            e.ferr = 1'b1;
            e.data = m_last;
            e.ovr  = 1'b0;
            e.perr = 1'b0;
        end
        sb.push_back(e);
        drive_frame(d, stop, par, gbit, -1);
    endtask

    task automatic idle(input int n);
        in_line = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Ack driver: raise ack in the cycle before the scheduled edge.
    initial begin
        forever begin
            @(negedge clk);
            ack = ack_at.exists(cyc + 1);
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ready || frame_err) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_output: got ready=%0b frame_err=%0b out=%02h, required none (cycle %0d)",
                             ready, frame_err, out, cyc);
                end else begin
                    e = sb.pop_front();
                    n_rx++;
                    $display("rx #%0d cycle %0d: out=%02h ready=%0b frame_err=%0b overrun=%0b parity_err=%0b",
                             n_rx, cyc, out, ready, frame_err, overrun, parity_err);
                    check("latency", cyc, e.when);
                    check("frame_err", frame_err, e.ferr);
                    check("ready", ready, !e.ferr);
                    check("out", out, e.data);
                    check("overrun", overrun, e.ovr);
                    check("parity_err", parity_err, e.perr);
                    if (!e.ferr) check("valid_set", valid, 1);
                end
            end else if (overrun || parity_err) begin
                n_cmp++;
                n_err++;
                $display("FAIL stray_flag: got overrun=%0b parity_err=%0b, required 0 (cycle %0d)",
                         overrun, parity_err, cyc);
            end
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL timeout: got no completion, required finish within 60000 cycles");
        $fatal(1, "timeout");
    end

    initial begin
        int n0;
        logic [7:0] d;
        bit stop, par;
        int gbit, mode;

        // Reset with idle line.
        reset_n = 1'b0;
        in_line = 1'b1;
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        check("rst_out", out, 0);
        check("rst_ready", ready, 0);
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_parity_err", parity_err, 0);

        // Reset mid-frame: no byte may appear (monitor flags any output).
        drive_frame(8'hFF, 1'b1, 1'b0, -1, 3);
        idle(3 * DIV);
        check("midrst_busy", busy, 0);
        check("midrst_valid", valid, 0);
        m_valid = 1'b0;
        m_last  = 8'h00;

        // Short glitch on idle line: busy during START, cleared after mid-start.
        n0 = cyc;
        in_line = 1'b0;
        repeat (3) @(negedge clk);
        in_line = 1'b1;
        check("glitch_busy_start", busy, 1);
        while (cyc < n0 + 10) @(negedge clk);
        check("glitch_busy_clear", busy, 0);
        idle(2 * DIV);

        // Directed bytes with ack.
        send_frame(8'hA9, 1'b1, ^8'hA9, -1, 0); idle(5);
        send_frame(8'h99, 1'b1, ^8'h99, -1, 0); idle(5);
        send_frame(8'hB1, 1'b1, ^8'hB1, -1, 0); idle(0);
        send_frame(8'hEA, 1'b1, ^8'hEA, -1, 0); idle(12);

        // Bad stop, then long low, then a clean byte.
        send_frame(8'h55, 1'b0, ^8'h55, -1, 0);
        in_line = 1'b0;
        repeat (30) @(negedge clk);
        idle(2 * DIV);
        send_frame(8'h3C, 1'b1, ^8'h3C, -1, 0); idle(12);

        // Overrun, then ack coincident with the second byte's decision.
        send_frame(8'h12, 1'b1, ^8'h12, -1, 1); idle(4);
        send_frame(8'h34, 1'b1, ^8'h34, -1, 1); idle(4);
        send_frame(8'h12, 1'b1, ^8'h12, -1, 1); idle(4);
        send_frame(8'h34, 1'b1, ^8'h34, -1, 2); idle(12);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1, -1, 0); idle(6);
        send_frame(8'h07, 1'b1, 1'b0, -1, 0); idle(6);
`endif

        // Randomized frames: gaps (including zero idle), mid-bit glitches,
        // bad stops, ack modes and, in the parity build, wrong parity.
        for (int i = 0; i < 40; i++) begin
            d    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 9) != 0);
            par  = (^d) ^ ($urandom_range(0, 3) == 0);
            gbit = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 8)) : -1;
            mode = int'($urandom_range(0, 2));
            send_frame(d, stop, par, gbit, mode);
            if (!stop) idle(DIV + int'($urandom_range(0, 10)));
            else if ($urandom_range(0, 1) == 1) idle(0);
            else idle(int'($urandom_range(1, 20)));
        end

        idle(1);
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        repeat (10) @(negedge clk);
        check("final_valid", valid, m_valid);
        check("final_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
